// File: rtl/lpc_pkg.sv
// Shared LPC definitions used by the host master and the LPC peripheral.
// Contents: host FSM state enumeration, START/CYCTYPE nibbles, SYNC codes,
// completion error codes and a helper that classifies SYNC wait codes.
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CYC,
        ST_ADDR,
        ST_WDATA,
        ST_TAR1,
        ST_TAR2,
        ST_SYNC,
        ST_RDATA,
        ST_PTAR,
        ST_ABORT,
        ST_ABORT_END
    } lpc_state_e;

    localparam logic [3:0] LPC_START  = 4'b0000;
    localparam logic [3:0] CYC_IO_RD  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;
    localparam logic [3:0] SYNC_NONE  = 4'b1111;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_SYNC   = 2'b01;
    localparam logic [1:0] ERR_ABORT  = 2'b10;

    // Codes that keep the host sitting in SYNC (and therefore need a timeout).
    function automatic logic is_wait_code(input logic [3:0] c);
        return (c == SYNC_SHORT) || (c == SYNC_LONG) || (c == SYNC_NONE);
    endfunction

endpackage

// File: rtl/lpc_sync_timer.sv
// Counts consecutive identical SYNC wait codes and flags when the run length
// exceeds the limit for that code.
// Ports:
//   CLK_IP_i, RST_IP_i : clock, async active-high reset
//   clear_i            : hold the counter at zero (host not in SYNC)
//   code_i             : LAD value sampled this SYNC clock
//   expired_o          : this sample pushes the run past its limit
module lpc_sync_timer
    import lpc_pkg::*;
#(
    parameter int NOSYNC_MAX     = 3,
    parameter int SHORT_WAIT_MAX = 8,
    parameter int LONG_WAIT_MAX  = 1024
) (
    input  logic       CLK_IP_i,
    input  logic       RST_IP_i,
    input  logic       clear_i,
    input  logic [3:0] code_i,
    output logic       expired_o
);

    localparam int MAX_A   = (NOSYNC_MAX > SHORT_WAIT_MAX) ? NOSYNC_MAX : SHORT_WAIT_MAX;
    localparam int MAX_ALL = (MAX_A > LONG_WAIT_MAX) ? MAX_A : LONG_WAIT_MAX;
    // Must hold MAX_ALL+1, the first value that trips the timeout.
    localparam int CNT_W   = $clog2(MAX_ALL + 2);

    logic [CNT_W-1:0] cnt_q, cnt_d, limit;
    logic [3:0]       code_q;
    logic             is_wait;

    always_comb begin
        is_wait = is_wait_code(code_i);
        limit   = '0;
        case (code_i)
            SYNC_NONE:  limit = CNT_W'(NOSYNC_MAX);
            SYNC_SHORT: limit = CNT_W'(SHORT_WAIT_MAX);
            SYNC_LONG:  limit = CNT_W'(LONG_WAIT_MAX);
            default:    limit = '0;
        endcase
        // A changed code restarts the run at one; cnt_q==0 marks "no run yet".
        if (clear_i || !is_wait)
            cnt_d = '0;
        else if ((code_i == code_q) && (cnt_q != '0))
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = CNT_W'(1);
        expired_o = is_wait && !clear_i && (cnt_d > limit);
    end

    always_ff @(posedge CLK_IP_i or posedge RST_IP_i) begin
        if (RST_IP_i) begin
            cnt_q  <= '0;
            code_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (!clear_i)
                code_q <= code_i;
        end
    end

endmodule

// File: rtl/lpc_host_master.sv
// LPC host master for single-byte I/O read/write cycles.
// Ports:
//   CLK_IP_i, RST_IP_i      : LPC clock, async active-high reset
//   req_*                   : request handshake (ready only in IDLE)
//   resp_*                  : one-cycle completion pulse with data/error
//   lpc_lframe_n/lreset_n   : LFRAME#, LRESET# (registered ~reset)
//   lpc_lad_out/oe/in       : LAD drive value, enable and sampled value
module lpc_host_master
    import lpc_pkg::*;
#(
    parameter int NOSYNC_MAX     = 3,
    parameter int SHORT_WAIT_MAX = 8,
    parameter int LONG_WAIT_MAX  = 1024
) (
    input  logic        CLK_IP_i,
    input  logic        RST_IP_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic [1:0]  resp_err,
    output logic        lpc_lframe_n,
    output logic        lpc_lreset_n,
    output logic [3:0]  lpc_lad_out,
    output logic        lpc_lad_oe,
    input  logic [3:0]  lpc_lad_in
);

    lpc_state_e  state_q, state_d;
    logic [1:0]  idx_q, idx_d;          // nibble / clock index within a phase
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic        resp_valid_q, resp_valid_d;
    logic [7:0]  resp_rdata_q, resp_rdata_d;
    logic [1:0]  resp_err_q, resp_err_d;
    logic        lreset_n_q;
    logic        timer_expired;

    assign req_ready    = (state_q == ST_IDLE) && !RST_IP_i;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign lpc_lreset_n = lreset_n_q;

    lpc_sync_timer #(
        .NOSYNC_MAX     (NOSYNC_MAX),
        .SHORT_WAIT_MAX (SHORT_WAIT_MAX),
        .LONG_WAIT_MAX  (LONG_WAIT_MAX)
    ) u_timer (
        .CLK_IP_i  (CLK_IP_i),
        .RST_IP_i  (RST_IP_i),
        .clear_i   (state_q != ST_SYNC),
        .code_i    (lpc_lad_in),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        lpc_lframe_n = 1'b1;
        lpc_lad_out  = 4'hF;
        lpc_lad_oe   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 8'h00;    // writes and early aborts report 00
                    err_d   = ERR_OK;
                    idx_d   = 2'd0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                lpc_lframe_n = 1'b0;
                lpc_lad_out  = LPC_START;
                lpc_lad_oe   = 1'b1;
                state_d      = ST_CYC;
            end
            ST_CYC: begin
                lpc_lad_out = write_q ? CYC_IO_WR : CYC_IO_RD;
                lpc_lad_oe  = 1'b1;
                idx_d       = 2'd0;
                state_d     = ST_ADDR;
            end
            ST_ADDR: begin
                lpc_lad_oe = 1'b1;
                case (idx_q)
                    2'd0:    lpc_lad_out = addr_q[15:12];
                    2'd1:    lpc_lad_out = addr_q[11:8];
                    2'd2:    lpc_lad_out = addr_q[7:4];
                    default: lpc_lad_out = addr_q[3:0];
                endcase
                idx_d = idx_q + 1'b1;
                if (idx_q == 2'd3)
                    state_d = write_q ? ST_WDATA : ST_TAR1;
            end
            ST_WDATA: begin
                lpc_lad_oe  = 1'b1;
                lpc_lad_out = idx_q[0] ? wdata_q[7:4] : wdata_q[3:0];
                idx_d       = idx_q + 1'b1;
                if (idx_q[0])
                    state_d = ST_TAR1;
            end
            ST_TAR1: begin
                lpc_lad_oe = 1'b1;
                state_d    = ST_TAR2;
            end
            ST_TAR2: begin
                state_d = ST_SYNC;
            end
            ST_SYNC: begin
                idx_d = 2'd0;
                if (lpc_lad_in == SYNC_READY) begin
                    state_d = write_q ? ST_PTAR : ST_RDATA;
                end else if (is_wait_code(lpc_lad_in)) begin
                    if (timer_expired) begin
                        err_d   = ERR_ABORT;
                        state_d = ST_ABORT;
                    end
                end else begin
                    // Error SYNC still runs the data/TAR clocks the peripheral expects.
                    err_d   = ERR_SYNC;
                    state_d = write_q ? ST_PTAR : ST_RDATA;
                end
            end
            ST_RDATA: begin
                idx_d = idx_q + 1'b1;
                if (idx_q[0]) begin
                    rdata_d = {lpc_lad_in, rdata_q[3:0]};
                    idx_d   = 2'd0;
                    state_d = ST_PTAR;
                end else begin
                    rdata_d = {rdata_q[7:4], lpc_lad_in};
                end
            end
            ST_PTAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q[0]) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = rdata_q;
                    resp_err_d   = err_q;
                    state_d      = ST_IDLE;
                end
            end
            ST_ABORT: begin
                lpc_lframe_n = 1'b0;
                lpc_lad_oe   = 1'b1;
                idx_d        = idx_q + 1'b1;
                if (idx_q == 2'd3)
                    state_d = ST_ABORT_END;
            end
            ST_ABORT_END: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = rdata_q;
                resp_err_d   = err_q;
                idx_d        = 2'd0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IP_i or posedge RST_IP_i) begin
        if (RST_IP_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            write_q      <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 8'h00;
            rdata_q      <= 8'h00;
            err_q        <= ERR_OK;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 8'h00;
            resp_err_q   <= ERR_OK;
            lreset_n_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            lreset_n_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lpc_host_master.sv
// Directed bench for lpc_host_master. Inputs change and outputs are sampled
// on the falling edge; cycle index k=0 is the START clock of a transaction.
module tb_lpc_host_master;

    logic        CLK_IP_i = 1'b0;
    logic        RST_IP_i = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic [1:0]  resp_err;
    logic        lpc_lframe_n;
    logic        lpc_lreset_n;
    logic [3:0]  lpc_lad_out;
    logic        lpc_lad_oe;
    logic [3:0]  lpc_lad_in = 4'hF;

    int checks = 0;
    int errors = 0;

    logic [3:0] pin [64];   // peripheral LAD value per cycle
    logic       lf  [64];
    logic       oe  [64];
    logic       rv  [64];
    logic [3:0] lo  [64];
    logic [7:0] rd  [64];
    logic [1:0] re  [64];

    lpc_host_master dut (
        .CLK_IP_i     (CLK_IP_i),
        .RST_IP_i     (RST_IP_i),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .lpc_lframe_n (lpc_lframe_n),
        .lpc_lreset_n (lpc_lreset_n),
        .lpc_lad_out  (lpc_lad_out),
        .lpc_lad_oe   (lpc_lad_oe),
        .lpc_lad_in   (lpc_lad_in)
    );

    always #5 CLK_IP_i = ~CLK_IP_i;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "bench timeout");
    end

    task automatic clear_pin;
        for (int k = 0; k < 64; k++) pin[k] = 4'hF;
    endtask

    // Call at a falling edge with the DUT idle; returns at the START falling edge.
    task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        @(negedge CLK_IP_i);
        req_valid = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            if (k != 0) @(negedge CLK_IP_i);
            lf[k] = lpc_lframe_n; oe[k] = lpc_lad_oe; lo[k] = lpc_lad_out;
            rv[k] = resp_valid;   rd[k] = resp_rdata; re[k] = resp_err;
            lpc_lad_in = pin[k];
        end
    endtask

    task automatic test_reset;
        RST_IP_i = 1'b1;
        repeat (3) @(negedge CLK_IP_i);
        checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_err} !== 12'h000) begin
            errors++; $display("FAIL reset_resp got %h exp 000", {req_ready, resp_valid, resp_rdata, resp_err});
        end
        checks++;
        if ({lpc_lframe_n, lpc_lad_out, lpc_lad_oe, lpc_lreset_n} !== 7'b1_1111_0_0) begin
            errors++; $display("FAIL reset_lpc got %b exp 1111100", {lpc_lframe_n, lpc_lad_out, lpc_lad_oe, lpc_lreset_n});
        end
        RST_IP_i = 1'b0;
        @(negedge CLK_IP_i);
        checks++;
        if ({req_ready, lpc_lreset_n} !== 2'b11) begin
            errors++; $display("FAIL reset_release got %b exp 11", {req_ready, lpc_lreset_n});
        end
    endtask

    // Read 0x03F8, two short waits, data C3.
    task automatic test_read_wait;
        logic [3:0] exp_lad [7];
        exp_lad = '{4'h0, 4'h0, 4'h0, 4'h3, 4'hF, 4'h8, 4'hF};
        @(negedge CLK_IP_i);
        clear_pin; pin[8] = 4'h5; pin[9] = 4'h5; pin[10] = 4'h0; pin[11] = 4'h3; pin[12] = 4'hC;
        issue(1'b0, 16'h03F8, 8'h00);
        capture(18);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (lo[k] !== exp_lad[k] || oe[k] !== 1'b1) begin
                errors++; $display("FAIL read_lad k=%0d got %h/%b exp %h/1", k, lo[k], oe[k], exp_lad[k]);
            end
        end
        checks++;
        if (oe[7] !== 1'b0 || oe[14] !== 1'b0 || lf[0] !== 1'b0 || lf[7] !== 1'b1) begin
            errors++; $display("FAIL read_oe got oe7=%b oe14=%b lf0=%b lf7=%b", oe[7], oe[14], lf[0], lf[7]);
        end
        checks++;
        if (rv[14] !== 1'b0 || rv[15] !== 1'b1 || rd[15] !== 8'hC3 || re[15] !== 2'b00) begin
            errors++; $display("FAIL read_resp got rv=%b%b rd=%h err=%b exp 01 c3 00", rv[14], rv[15], rd[15], re[15]);
        end
        checks++;
        if (rv[16] !== 1'b0 || rd[17] !== 8'hC3) begin
            errors++; $display("FAIL read_hold got rv=%b rd=%h exp 0 c3", rv[16], rd[17]);
        end
    endtask

    // Write 0x0080 <- 0x5A, immediate ready.
    task automatic test_write;
        logic [3:0] exp_lad [9];
        exp_lad = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'hA, 4'h5, 4'hF};
        @(negedge CLK_IP_i);
        clear_pin; pin[10] = 4'h0;
        issue(1'b1, 16'h0080, 8'h5A);
        capture(15);
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (lo[k] !== exp_lad[k] || oe[k] !== 1'b1) begin
                errors++; $display("FAIL write_lad k=%0d got %h/%b exp %h/1", k, lo[k], oe[k], exp_lad[k]);
            end
        end
        for (int k = 9; k < 14; k++) begin
            checks++;
            if (oe[k] !== 1'b0 || lf[k] !== 1'b1) begin
                errors++; $display("FAIL write_release k=%0d got oe=%b lf=%b exp 0 1", k, oe[k], lf[k]);
            end
        end
        checks++;
        if (lf[0] !== 1'b0 || lf[1] !== 1'b1) begin
            errors++; $display("FAIL write_lframe got %b%b exp 01", lf[0], lf[1]);
        end
        checks++;
        if (rv[12] !== 1'b0 || rv[13] !== 1'b1 || rv[14] !== 1'b0 || re[13] !== 2'b00 || rd[13] !== 8'h00) begin
            errors++; $display("FAIL write_resp got rv=%b%b%b err=%b rd=%h exp 010 00 00", rv[12], rv[13], rv[14], re[13], rd[13]);
        end
    endtask

    // Read with no response: four 1111 SYNC clocks then abort.
    task automatic test_nosync;
        @(negedge CLK_IP_i);
        clear_pin;
        issue(1'b0, 16'h0060, 8'h00);
        capture(19);
        checks++;
        if (lf[11] !== 1'b1 || oe[11] !== 1'b0) begin
            errors++; $display("FAIL nosync_early got lf=%b oe=%b exp 1 0", lf[11], oe[11]);
        end
        for (int k = 12; k < 16; k++) begin
            checks++;
            if (lf[k] !== 1'b0 || oe[k] !== 1'b1 || lo[k] !== 4'hF) begin
                errors++; $display("FAIL nosync_abort k=%0d got lf=%b oe=%b lad=%h exp 0 1 f", k, lf[k], oe[k], lo[k]);
            end
        end
        checks++;
        if (lf[16] !== 1'b1 || oe[16] !== 1'b0 || rv[16] !== 1'b0) begin
            errors++; $display("FAIL nosync_end got lf=%b oe=%b rv=%b exp 1 0 0", lf[16], oe[16], rv[16]);
        end
        checks++;
        if (rv[17] !== 1'b1 || re[17] !== 2'b10 || rd[17] !== 8'h00 || rv[18] !== 1'b0) begin
            errors++; $display("FAIL nosync_resp got rv=%b err=%b rd=%h rv18=%b exp 1 10 00 0", rv[17], re[17], rd[17], rv[18]);
        end
    endtask

    // Write with error SYNC 1010.
    task automatic test_sync_err;
        @(negedge CLK_IP_i);
        clear_pin; pin[10] = 4'hA;
        issue(1'b1, 16'h0070, 8'h3C);
        capture(15);
        checks++;
        if (lf[11] !== 1'b1 || oe[11] !== 1'b0 || oe[12] !== 1'b0 || rv[12] !== 1'b0) begin
            errors++; $display("FAIL syncerr_tar got lf=%b oe=%b%b rv=%b", lf[11], oe[11], oe[12], rv[12]);
        end
        checks++;
        if (rv[13] !== 1'b1 || re[13] !== 2'b01) begin
            errors++; $display("FAIL syncerr_resp got rv=%b err=%b exp 1 01", rv[13], re[13]);
        end
    endtask

    // Short-wait limit: nine 0101 aborts, eight then ready succeeds.
    task automatic test_short_wait;
        @(negedge CLK_IP_i);
        clear_pin;
        for (int k = 10; k < 19; k++) pin[k] = 4'h5;
        issue(1'b1, 16'h0011, 8'h22);
        capture(26);
        checks++;
        if (lf[18] !== 1'b1 || oe[18] !== 1'b0 || lf[19] !== 1'b0 || oe[19] !== 1'b1) begin
            errors++; $display("FAIL short_abort_edge got lf=%b%b oe=%b%b exp 10 01", lf[18], lf[19], oe[18], oe[19]);
        end
        checks++;
        if (rv[24] !== 1'b1 || re[24] !== 2'b10) begin
            errors++; $display("FAIL short_abort_resp got rv=%b err=%b exp 1 10", rv[24], re[24]);
        end
        clear_pin;
        for (int k = 10; k < 18; k++) pin[k] = 4'h5;
        pin[18] = 4'h0;
        issue(1'b1, 16'h0011, 8'h22);
        capture(23);
        checks++;
        if (lf[19] !== 1'b1 || rv[20] !== 1'b0 || rv[21] !== 1'b1 || re[21] !== 2'b00) begin
            errors++; $display("FAIL short_ok got lf=%b rv=%b%b err=%b exp 1 01 00", lf[19], rv[20], rv[21], re[21]);
        end
    endtask

    // A different wait code restarts the run count.
    task automatic test_wait_change;
        @(negedge CLK_IP_i);
        clear_pin;
        for (int k = 10; k < 18; k++) pin[k] = 4'h5;
        pin[18] = 4'h6;
        for (int k = 19; k < 27; k++) pin[k] = 4'h5;
        pin[27] = 4'h0;
        issue(1'b1, 16'h0012, 8'h33);
        capture(32);
        checks++;
        if (lf[26] !== 1'b1 || lf[28] !== 1'b1 || rv[29] !== 1'b0 || rv[30] !== 1'b1 || re[30] !== 2'b00) begin
            errors++; $display("FAIL wait_change got lf=%b%b rv=%b%b err=%b exp 11 01 00", lf[26], lf[28], rv[29], rv[30], re[30]);
        end
    endtask

    // Reset during the address phase.
    task automatic test_reset_mid;
        logic seen;
        seen = 1'b0;
        @(negedge CLK_IP_i);
        clear_pin;
        issue(1'b1, 16'h1234, 8'h55);
        repeat (3) @(negedge CLK_IP_i);
        checks++;
        if (lpc_lad_oe !== 1'b1 || lpc_lad_out !== 4'h2) begin
            errors++; $display("FAIL rstmid_pre got oe=%b lad=%h exp 1 2", lpc_lad_oe, lpc_lad_out);
        end
        #2 RST_IP_i = 1'b1;
        #1;
        checks++;
        if (lpc_lad_oe !== 1'b0 || lpc_lframe_n !== 1'b1 || lpc_lad_out !== 4'hF || req_ready !== 1'b0 || lpc_lreset_n !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got oe=%b lf=%b lad=%h rdy=%b lrst=%b exp 0 1 f 0 0",
                               lpc_lad_oe, lpc_lframe_n, lpc_lad_out, req_ready, lpc_lreset_n);
        end
        @(negedge CLK_IP_i);
        RST_IP_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK_IP_i);
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_noresp got seen=%b rdy=%b exp 0 1", seen, req_ready);
        end
    endtask

    // New request accepted in the resp_valid cycle starts on the next clock.
    task automatic test_back_to_back;
        @(negedge CLK_IP_i);
        clear_pin; pin[10] = 4'h0;
        issue(1'b1, 16'h0020, 8'h11);
        capture(14);
        checks++;
        if (rv[13] !== 1'b1 || req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready got rv=%b rdy=%b exp 1 1", rv[13], req_ready);
        end
        clear_pin; pin[8] = 4'h0; pin[9] = 4'h7; pin[10] = 4'h2;
        issue(1'b0, 16'h0021, 8'h00);
        capture(15);
        checks++;
        if (lf[0] !== 1'b0 || oe[0] !== 1'b1 || lo[0] !== 4'h0 || lo[1] !== 4'h0) begin
            errors++; $display("FAIL b2b_start got lf=%b oe=%b lad=%h%h exp 0 1 00", lf[0], oe[0], lo[0], lo[1]);
        end
        checks++;
        if (rv[13] !== 1'b1 || rd[13] !== 8'h27 || re[13] !== 2'b00) begin
            errors++; $display("FAIL b2b_resp got rv=%b rd=%h err=%b exp 1 27 00", rv[13], rd[13], re[13]);
        end
    endtask

    initial begin
        clear_pin;
        test_reset;
        test_read_wait;
        test_write;
        test_nosync;
        test_sync_err;
        test_short_wait;
        test_wait_change;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_host_master.md
LPC_HOST_MASTER -- requirements
Module: lpc_host_master

Interface
REQ-001 SHALL have parameter NOSYNC_MAX, default 3: maximum consecutive SYNC=1111 clocks before abort.
REQ-002 SHALL have parameter SHORT_WAIT_MAX, default 8: maximum consecutive SYNC=0101 clocks before abort.
REQ-003 SHALL have parameter LONG_WAIT_MAX, default 1024: maximum consecutive SYNC=0110 clocks before abort.
REQ-004 SHALL have one clock and an asynchronous, active-high reset:
  CLK_IP_i  in  1  LPC clock, 33 MHz, all logic on rising edge.
  RST_IP_i  in  1  asynchronous active-high reset.
REQ-005 SHALL have these ports:
  req_valid  in  1  request present.
  req_ready  out  1  request accepted when req_valid && req_ready.
  req_write  in  1  1 = I/O write, 0 = I/O read.
  req_addr  in  16  I/O address.
  req_wdata  in  8  write data.
  resp_valid  out  1  one-cycle completion pulse.
  resp_rdata  out  8  read data, valid with resp_valid.
  resp_err  out  2  00 ok, 01 SYNC error (1010 or illegal code), 10 timeout/abort.
  lpc_lframe_n  out  1  LFRAME#.
  lpc_lreset_n  out  1  LRESET#.
  lpc_lad_out  out  4  LAD drive value.
  lpc_lad_oe  out  1  LAD output enable; the top level owns the tri-state pad.
  lpc_lad_in  in  4  LAD sampled value.

Function
REQ-006 SHALL set req_ready=1 only in IDLE, and SHALL register req_write, req_addr and req_wdata at acceptance.
REQ-007 SHALL, for the request accepted at edge N, drive START=0000 with lpc_lframe_n=0 in cycle N+1, and SHALL hold lpc_lframe_n=1 in every other non-ABORT cycle.
REQ-008 SHALL drive CYCTYPE/DIR next: 0010 for write, 0000 for read.
REQ-009 SHALL then drive address nibbles addr[15:12], [11:8], [7:4], [3:0] in that order.
REQ-010 SHALL, for writes, then drive wdata[3:0] followed by wdata[7:4].
REQ-011 SHALL then perform host TAR: cycle 1 drives 1111 with oe=1; cycle 2 sets oe=0.
REQ-012 SHALL keep oe=0 from TAR cycle 2 until return to IDLE, and SHALL keep oe=0 and lad_out=1111 in IDLE.
REQ-013 SHALL sample lpc_lad_in each SYNC cycle and act on the value:
  - 0000 ready: reads capture the next two nibbles as rdata[3:0] then rdata[7:4].
  - 0101 or 0110: wait.
  - 1111: no response.
  - 1010 or any other value: error, resp_err=01.
REQ-014 SHALL, after an error SYNC on a read, still consume the two data clocks, then proceed to peripheral TAR.
REQ-015 SHALL follow the final SYNC (writes) or final data nibble (reads) with two peripheral-TAR clocks (oe=0), then return to IDLE.
REQ-016 SHALL give a minimum transaction time of 13 clocks from START to the last TAR for both reads and writes.
REQ-017 SHALL count consecutive identical wait codes with a counter that resets when the code changes.
REQ-018 SHALL enter ABORT when a wait count exceeds NOSYNC_MAX, SHORT_WAIT_MAX or LONG_WAIT_MAX for the respective code.
REQ-019 SHALL, in ABORT, drive lframe_n=0, lad_out=1111, oe=1 for exactly 4 clocks, then one clock with lframe_n=1 and oe=0, then return to IDLE with resp_err=10.
REQ-020 SHALL assert resp_valid for exactly one cycle, in the first IDLE cycle after completion, and a new request SHALL be acceptable in that same cycle.
REQ-021 SHALL hold resp_rdata stable until the next resp_valid; resp_rdata SHALL be 00 on writes.
REQ-022 SHALL drive lpc_lreset_n as a registered ~RST_IP_i.

Reset
REQ-023 SHALL, while RST_IP_i=1, hold: state=IDLE, req_ready=0, resp_valid=0, resp_rdata=00, resp_err=00, lframe_n=1, lad_out=1111, oe=0, lreset_n=0, counters=0.
REQ-024 SHALL, on reset mid-transaction, release LAD immediately and emit no resp_valid for the lost request.
REQ-025 SHALL assert req_ready on the first clock after reset deassertion.

Structure
REQ-026 SHALL place the state enumeration, the CYCTYPE codes (0000/0010), the SYNC codes (0000, 0101, 0110, 1010, 1111) and the resp_err codes in shared package lpc_pkg, which the existing LPC peripheral also uses.
REQ-027 SHALL implement the wait/timeout counter as one sub-module, lpc_sync_timer, with code-in, clear and expired outputs.

Verification
REQ-028 Write 0x0080 ← 0x5A, peripheral SYNC=0000 on first SYNC clock -> LAD sequence 0000,0010,0,0,8,0,A,5,F,Z, SYNC; resp_valid exactly 13 clocks after START with resp_err=00.
REQ-029 Read 0x03F8, peripheral 0101 ×2, 0000, data nibbles 3,C -> resp_rdata=0xC3, resp_err=00, total 15 clocks.
REQ-030 Read with peripheral holding 1111 -> after 4 SYNC clocks, ABORT (lframe_n=0 4 clocks, LAD=1111), resp_err=10.
REQ-031 Write with SYNC=1010 -> peripheral TAR completes normally, resp_err=01.
REQ-032 SHORT_WAIT_MAX+1 consecutive 0101 codes -> abort; SHORT_WAIT_MAX codes followed by 0000 -> success.
REQ-033 RST_IP_i asserted during ADDR -> oe=0 and lframe_n=1 asynchronously, no resp_valid; back-to-back request accepted in the resp_valid cycle starts START on the next clock.
